// File: rtl/lbist_cut_ctrl.sv
// Logic BIST controller: LFSR pattern source, MISR response compactor, golden compare.
// The CUT sits beside this block; cut_in_o feeds it and cut_out_i returns its response.
module lbist_cut_ctrl #(
  parameter int                 N_IN       = 5,
  parameter int                 N_OUT      = 2,
  parameter int                 N_PATTERNS = 31,
  parameter logic [N_IN-1:0]    SEED       = 5'h01,
  parameter int                 MISR_W     = 8,
  parameter logic [MISR_W-1:0]  MISR_POLY  = 8'h1D,
  parameter logic [MISR_W-1:0]  GOLDEN     = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [N_IN-1:0]   cut_in_o,
  input  logic [N_OUT-1:0]  cut_out_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [MISR_W-1:0] signature_o,
  output logic [4:0]        pat_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEED = 3'd1,
    S_RUN  = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [N_IN-1:0] SEED_EFF = (SEED == '0) ? N_IN'(1) : SEED;
  localparam logic [4:0]      LAST_CNT = 5'(N_PATTERNS - 1);

  state_t              state_q, state_d;
  logic [N_IN-1:0]     lfsr_q, lfsr_d;
  logic [N_IN-1:0]     cut_q, cut_d;
  logic [MISR_W-1:0]   misr_q, misr_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                pass_q, pass_d;

  function automatic logic [N_IN-1:0] lfsr_step(input logic [N_IN-1:0] x);
    return {x[N_IN-2:0], x[4] ^ x[2]};
  endfunction

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [N_OUT-1:0]  r);
    return {m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? MISR_POLY : '0) ^ MISR_W'(r);
  endfunction

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        pass_d = 1'b0;
        if (start_i) state_d = S_SEED;
      end
      S_SEED: begin
        lfsr_d  = SEED_EFF;
        misr_d  = '0;
        cnt_d   = '0;
        pass_d  = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // cut_out_i reflects the pattern held on cut_in_o for the whole cycle.
        misr_d = misr_step(misr_q, cut_out_i);
        lfsr_d = lfsr_step(lfsr_q);
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) state_d = S_CMP;
      end
      S_CMP: begin
        pass_d  = (misr_q == GOLDEN);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (start_i) begin
          pass_d  = 1'b0;
          state_d = S_SEED;
        end
      end
      default: begin
        pass_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // Abort wins over everything; signature and count freeze for inspection.
    if (abort_i) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      cnt_d   = cnt_q;
    end
    cut_d = (state_d == S_RUN) ? lfsr_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      cut_q   <= '0;
      misr_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cut_q   <= cut_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign cut_in_o    = cut_q;
  assign busy_o      = (state_q == S_SEED) || (state_q == S_RUN) || (state_q == S_CMP);
  assign done_o      = (state_q == S_DONE);
  assign pass_o      = pass_q && (state_q == S_DONE);
  assign signature_o = misr_q;
  assign pat_cnt_o   = cnt_q;

endmodule
